// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT frame scheduler slice.
// Default geometry matches the production core; modules override via parameters.
package ntt_pkg;

    localparam int DEF_LANE_WIDTH      = 28;
    localparam int DEF_LANES           = 32;
    localparam int DEF_BEATS_PER_FRAME = 32;

    typedef logic [DEF_LANE_WIDTH-1:0] lane_t;
    typedef lane_t [DEF_LANES-1:0]     beat_t;

    typedef logic [0:0] feed_state_e;
    localparam feed_state_e IDLE = 1'b0;
    localparam feed_state_e FEED = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BEAT_CNT_W = cnt_width(DEF_BEATS_PER_FRAME);

endpackage

// File: rtl/ntt_sync_fifo.sv
// First-word fall-through synchronous FIFO; storage array has a registered read
// feeding an output register, with a bypass when the array is empty.
module ntt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] ram_count_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;

    logic do_pop;
    logic do_push;
    logic load;
    logic ram_rd;
    logic ram_wr;
    logic bypass;

    // A pop frees the head slot, so a push while full is still accepted.
    always_comb begin
        do_pop  = pop && out_valid_reg;
        do_push = push && (!full || do_pop);
        load    = !out_valid_reg || do_pop;
        ram_rd  = load && (ram_count_reg != '0);
        bypass  = load && (ram_count_reg == '0) && do_push;
        ram_wr  = do_push && !bypass;
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg <= '0;
        end else if (ram_rd) begin
            out_data_reg <= mem[rd_ptr_reg];
        end else if (bypass) begin
            out_data_reg <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (ram_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            ram_count_reg <= ram_count_reg + CNT_W'(ram_wr) - CNT_W'(ram_rd);
            if (load) begin
                out_valid_reg <= ram_rd || bypass;
            end
        end
    end

    assign pop_data = out_data_reg;
    assign count    = ram_count_reg + CNT_W'(out_valid_reg);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = !out_valid_reg;

endmodule

// File: rtl/ntt_frame_scheduler.sv
// Buffers whole input frames, launches them into the non-stallable NTT core
// only when output space is reserved, and captures the core's output burst.
module ntt_frame_scheduler
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = DEF_LANE_WIDTH,
    parameter int INPUT_PER_CYCLE      = DEF_LANES,
    parameter int BEATS_PER_FRAME      = DEF_BEATS_PER_FRAME,
    parameter int OUT_FRAMES           = 2,
    parameter int IN_FRAMES            = 2,
    localparam int DW     = DATA_WIDTH_PER_INPUT * INPUT_PER_CYCLE,
    localparam int CRED_W = $clog2(OUT_FRAMES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              core_in_start,
    output logic [DW-1:0]     core_in_data,
    input  logic              core_out_start,
    input  logic [DW-1:0]     core_out_data,
    output logic [DW-1:0]     m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CRED_W-1:0] inflight,
    output logic              err
);

    localparam int W         = DATA_WIDTH_PER_INPUT;
    localparam int CNT_W     = cnt_width(BEATS_PER_FRAME);
    localparam int FR_W      = $clog2(IN_FRAMES + 1);
    localparam int IN_DEPTH  = IN_FRAMES * BEATS_PER_FRAME;
    localparam int OUT_DEPTH = OUT_FRAMES * BEATS_PER_FRAME;
    localparam int IN_CNT_W  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CNT_W = $clog2(OUT_DEPTH + 1);

    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [CRED_W-1:0]   MAX_CRED = CRED_W'(OUT_FRAMES);
    localparam logic [FR_W-1:0]     MAX_FR   = FR_W'(IN_FRAMES);
    localparam logic [IN_CNT_W-1:0] FRAME_SZ = IN_CNT_W'(BEATS_PER_FRAME);

    logic [DW-1:0]        in_dout;
    logic                 in_full;
    logic                 in_empty_unused;
    logic [IN_CNT_W-1:0]  in_count;
    logic [DW-1:0]        out_dout;
    logic                 out_full;
    logic                 out_empty;
    logic [OUT_CNT_W-1:0] out_count_unused;

    logic [CNT_W-1:0]  in_beat_reg;
    logic [FR_W-1:0]   frames_ready_reg;
    logic [FR_W-1:0]   frames_ready_next;
    logic [CRED_W-1:0] credits_reg;
    logic [CRED_W-1:0] credits_next;
    feed_state_e       state_reg;
    feed_state_e       state_next;
    logic [CNT_W-1:0]  feed_cnt_reg;
    logic [CNT_W-1:0]  feed_cnt_next;
    logic              core_in_start_reg;
    logic [W-1:0]      lane_reg [INPUT_PER_CYCLE];
    logic              cap_active_reg;
    logic [CNT_W-1:0]  cap_cnt_reg;
    logic [CNT_W-1:0]  out_beat_reg;
    logic              err_reg;

    logic in_push;
    logic last_idx;
    logic frame_done;
    logic framing_err;
    logic launch_ok;
    logic launch;
    logic feed_pop;
    logic first_beat;
    logic cap_write;
    logic overlap_err;
    logic overflow_err;
    logic drain;
    logic credit_ret;

    ntt_sync_fifo #(.WIDTH(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_push),
        .push_data (s_data),
        .pop       (feed_pop),
        .pop_data  (in_dout),
        .full      (in_full),
        .empty     (in_empty_unused),
        .count     (in_count)
    );

    ntt_sync_fifo #(.WIDTH(DW), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_write),
        .push_data (core_out_data),
        .pop       (m_ready),
        .pop_data  (out_dout),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count_unused)
    );

    assign s_ready     = !in_full;
    assign in_push     = s_valid && s_ready;
    assign last_idx    = (in_beat_reg == LAST_IDX);
    assign frame_done  = in_push && s_last && last_idx;
    assign framing_err = in_push && (s_last != last_idx);
    assign launch_ok   = (frames_ready_reg != '0) && (credits_reg != '0) && (in_count >= FRAME_SZ);

    // Beat 0 is popped in the launch cycle itself; a relaunch on the last pop
    // leaves feed_cnt at 0 so the next frame follows without a gap.
    always_comb begin
        state_next    = state_reg;
        feed_cnt_next = feed_cnt_reg;
        launch        = 1'b0;
        feed_pop      = 1'b0;
        first_beat    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch_ok) begin
                    launch        = 1'b1;
                    feed_pop      = 1'b1;
                    first_beat    = 1'b1;
                    state_next    = FEED;
                    feed_cnt_next = CNT_W'(1);
                end
            end
            FEED: begin
                feed_pop      = 1'b1;
                first_beat    = (feed_cnt_reg == '0);
                feed_cnt_next = feed_cnt_reg + CNT_W'(1);
                if (feed_cnt_reg == LAST_IDX) begin
                    if (launch_ok) begin
                        launch = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign drain        = m_valid && m_ready;
    assign credit_ret   = drain && m_last;
    assign cap_write    = cap_active_reg || core_out_start;
    assign overlap_err  = cap_active_reg && core_out_start;
    assign overflow_err = cap_write && out_full && !drain;

    // Credits clamp at the ceiling so a spurious output frame cannot mint credit.
    always_comb begin
        frames_ready_next = frames_ready_reg;
        if (frame_done && !launch && frames_ready_reg != MAX_FR) begin
            frames_ready_next = frames_ready_reg + FR_W'(1);
        end else if (!frame_done && launch) begin
            frames_ready_next = frames_ready_reg - FR_W'(1);
        end
        credits_next = credits_reg;
        if (credit_ret && !launch && credits_reg != MAX_CRED) begin
            credits_next = credits_reg + CRED_W'(1);
        end else if (!credit_ret && launch) begin
            credits_next = credits_reg - CRED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_beat_reg       <= '0;
            frames_ready_reg  <= '0;
            credits_reg       <= MAX_CRED;
            state_reg         <= IDLE;
            feed_cnt_reg      <= '0;
            core_in_start_reg <= 1'b0;
            cap_active_reg    <= 1'b0;
            cap_cnt_reg       <= '0;
            out_beat_reg      <= '0;
            err_reg           <= 1'b0;
        end else begin
            if (in_push) begin
                in_beat_reg <= in_beat_reg + CNT_W'(1);
            end
            frames_ready_reg  <= frames_ready_next;
            credits_reg       <= credits_next;
            state_reg         <= state_next;
            feed_cnt_reg      <= feed_cnt_next;
            core_in_start_reg <= feed_pop && first_beat;
            if (cap_active_reg) begin
                cap_cnt_reg <= cap_cnt_reg + CNT_W'(1);
                if (cap_cnt_reg == LAST_IDX) begin
                    cap_active_reg <= 1'b0;
                end
            end else if (core_out_start) begin
                cap_active_reg <= 1'b1;
                cap_cnt_reg    <= CNT_W'(1);
            end
            if (drain) begin
                out_beat_reg <= out_beat_reg + CNT_W'(1);
            end
            err_reg <= err_reg || framing_err || overlap_err || overflow_err;
        end
    end

    // Per-lane core feed register; lanes are forced to zero between frames.
    for (genvar gi = 0; gi < INPUT_PER_CYCLE; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg[gi] <= '0;
            end else begin
                lane_reg[gi] <= feed_pop ? in_dout[gi*W +: W] : '0;
            end
        end
        assign core_in_data[gi*W +: W] = lane_reg[gi];
    end

    assign core_in_start = core_in_start_reg;
    assign m_valid       = !out_empty;
    assign m_data        = out_dout;
    assign m_last        = m_valid && (out_beat_reg == LAST_IDX);
    assign inflight      = MAX_CRED - credits_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// Directed bench for ntt_frame_scheduler with a fixed-delay behavioural core.
module tb_ntt_frame_scheduler;

    localparam int W   = 8;
    localparam int P   = 2;
    localparam int B   = 4;
    localparam int DW  = W * P;
    localparam int DLY = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          core_in_start;
    logic [DW-1:0] core_in_data;
    logic          core_out_start;
    logic [DW-1:0] core_out_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [1:0]    inflight;
    logic          err;
    logic          inject = 1'b0;

    logic [DLY-1:0] dly_start;
    logic [DW-1:0]  dly_data [DLY];

    int checks    = 0;
    int errors    = 0;
    int launches  = 0;
    int out_beats = 0;
    int feed_left = 0;
    int out_idx   = 0;
    logic [DW-1:0] exp_feed [$];
    logic [DW-1:0] exp_out  [$];

    always #5 clk = ~clk;

    ntt_frame_scheduler #(
        .DATA_WIDTH_PER_INPUT (W),
        .INPUT_PER_CYCLE      (P),
        .BEATS_PER_FRAME      (B),
        .OUT_FRAMES           (2),
        .IN_FRAMES            (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .core_in_start  (core_in_start),
        .core_in_data   (core_in_data),
        .core_out_start (core_out_start),
        .core_out_data  (core_out_data),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .inflight       (inflight),
        .err            (err)
    );

    // Behavioural core: output is the input delayed by DLY cycles.
    always @(posedge clk) begin
        if (rst) begin
            dly_start <= '0;
            for (int i = 0; i < DLY; i++) dly_data[i] <= '0;
        end else begin
            dly_start   <= {dly_start[DLY-2:0], core_in_start};
            dly_data[0] <= core_in_data;
            for (int i = 1; i < DLY; i++) dly_data[i] <= dly_data[i-1];
        end
    end
    assign core_out_start = dly_start[DLY-1] | inject;
    assign core_out_data  = dly_data[DLY-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int f, input int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(f * 16 + k);
        hi = 8'(f * 16 + k + 1);
        return {hi, lo};
    endfunction

    // Core feed monitor: every launch must deliver B contiguous beats in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_in_start) begin
                check("start_mid_frame", feed_left, 0);
                launches++;
                $display("launch %0d at %0t", launches, $time);
                feed_left = B;
            end
            if (feed_left > 0) begin
                if (exp_feed.size() == 0) begin
                    check("feed_extra", exp_feed.size(), 1);
                end else begin
                    check("feed_data", core_in_data, exp_feed.pop_front());
                end
                feed_left--;
            end else begin
                check("feed_idle_zero", core_in_data, 0);
            end
        end
    end

    // Output monitor: scoreboard every accepted downstream beat.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_out.size() == 0) begin
                check("out_extra", exp_out.size(), 1);
            end else begin
                check("out_data", m_data, exp_out.pop_front());
            end
            check("out_last", m_last, (out_idx == B - 1));
            $display("out beat %0d data=%h last=%b", out_beats, m_data, m_last);
            out_idx   = (out_idx + 1) % B;
            out_beats++;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int   guard;
        logic ok;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) check("s_ready_timeout", ok, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic send_frame(input int f, input int max_gap);
        for (int k = 0; k < B; k++) begin
            exp_feed.push_back(beat(f, k));
            exp_out.push_back(beat(f, k));
        end
        for (int k = 0; k < B; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_beat(beat(f, k), k == B - 1);
        end
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while (out_beats < n && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("out_count", out_beats, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_feed.delete();
        exp_out.delete();
        feed_left = 0;
        out_idx   = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_core_start", core_in_start, 0);
        check("rst_core_data", core_in_data, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err, 0);

        // 1: single frame, lanes {k,k+1}
        m_ready = 1'b1;
        send_frame(0, 0);
        check("t1_start_early", core_in_start, 0);
        @(posedge clk);
        #1;
        check("t1_start_latency", core_in_start, 1);
        check("t1_inflight_busy", inflight, 1);
        wait_out(4);
        repeat (2) @(posedge clk);
        #1;
        check("t1_launches", launches, 1);
        check("t1_inflight", inflight, 0);
        check("t1_err", err, 0);

        // 2: three frames with the consumer stalled
        m_ready = 1'b0;
        send_frame(1, 0);
        send_frame(2, 0);
        send_frame(3, 0);
        repeat (30) @(posedge clk);
        #1;
        check("t2_launches", launches, 3);
        check("t2_inflight", inflight, 2);
        check("t2_m_valid", m_valid, 1);
        check("t2_out_held", out_beats, 4);
        m_ready = 1'b1;
        n = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (m_valid && m_last) break;
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (core_in_start) begin
                n = i;
                break;
            end
        end
        check("t2_relaunch_gap", n, 2);
        @(posedge clk);
        #1;
        wait_out(16);
        repeat (2) @(posedge clk);
        #1;
        check("t2_launches_all", launches, 4);
        check("t2_inflight_end", inflight, 0);
        check("t2_queue_empty", exp_out.size(), 0);
        check("t2_err", err, 0);

        // 3: random input gaps and random consumer stalls
        fork
            begin
                for (int f = 4; f < 8; f++) send_frame(f, 2);
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        wait_out(32);
        repeat (2) @(posedge clk);
        #1;
        check("t3_launches", launches, 8);
        check("t3_inflight", inflight, 0);
        check("t3_queue_empty", exp_out.size(), 0);
        check("t3_err", err, 0);

        // 4: s_last on beat index 1
        send_beat(beat(9, 0), 1'b0);
        send_beat(beat(9, 1), 1'b1);
        @(posedge clk);
        #1;
        check("t4_err_set", err, 1);
        repeat (6) @(posedge clk);
        #1;
        check("t4_err_sticky", err, 1);
        check("t4_no_launch", launches, 8);
        do_reset();
        check("t4_err_cleared", err, 0);

        // 5: two core_out_start pulses two cycles apart
        m_ready = 1'b1;
        base = out_beats;
        for (int k = 0; k < B; k++) exp_out.push_back('0);
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        @(posedge clk);
        #1;
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        wait_out(base + 4);
        repeat (6) @(posedge clk);
        #1;
        check("t5_capture_len", out_beats, base + 4);
        check("t5_err", err, 1);
        check("t5_inflight", inflight, 0);
        do_reset();

        // 6: reset in the middle of a feed, then a clean frame
        base = launches;
        send_frame(10, 0);
        @(posedge clk);
        #1;
        check("t6_in_feed", core_in_start, 1);
        do_reset();
        check("t6_s_ready", s_ready, 1);
        check("t6_m_valid", m_valid, 0);
        check("t6_inflight", inflight, 0);
        check("t6_core_start", core_in_start, 0);
        check("t6_err", err, 0);
        base = out_beats;
        send_frame(11, 0);
        wait_out(base + 4);
        repeat (2) @(posedge clk);
        #1;
        check("t6_inflight_end", inflight, 0);
        check("t6_queue_empty", exp_out.size(), 0);
        check("t6_err_end", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
